// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports (P = pipeline MEM stage, D = loader) and the data-memory port.
// The arbiter takes the slave view; the requesters and the memory take the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              P_Req;
    logic              P_Wr;
    logic [ADDR_W-1:0] P_Addr;
    logic [DATA_W-1:0] P_WData;
    logic [DATA_W-1:0] P_RData;
    logic              P_Ack;
    logic              Stall;

    logic              D_Req;
    logic              D_Wr;
    logic [ADDR_W-1:0] D_Addr;
    logic [DATA_W-1:0] D_WData;
    logic [DATA_W-1:0] D_RData;
    logic              D_Ack;

    logic              MemW;
    logic              MemR;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] MemoryOut;

    modport slave (
        input  P_Req, P_Wr, P_Addr, P_WData,
        output P_RData, P_Ack, Stall,
        input  D_Req, D_Wr, D_Addr, D_WData,
        output D_RData, D_Ack,
        output MemW, MemR, Address, DataIn,
        input  MemoryOut
    );

    modport master (
        output P_Req, P_Wr, P_Addr, P_WData,
        input  P_RData, P_Ack, Stall,
        output D_Req, D_Wr, D_Addr, D_WData,
        input  D_RData, D_Ack,
        input  MemW, MemR, Address, DataIn,
        output MemoryOut
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: serialises P/D requests into single-cycle memory commands
// (IDLE -> ISSUE -> DONE), returns read data, and stalls the pipeline while a P access is pending.
module dmem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    dmem_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]        state_q,   state_d;
    logic              gnt_d_q,   gnt_d_d;     // 1 = loader owns the current access
    logic              wr_q,      wr_d;
    logic [3:0]        starve_q,  starve_d;
    logic              memw_q,    memw_d;
    logic              memr_q,    memr_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              p_ack_q,   p_ack_d;
    logic              d_ack_q,   d_ack_d;

    logic d_win;

    // P has priority unless D is alone or P has used up its allowance while D waited.
    assign d_win = bus.D_Req & (~bus.P_Req | (starve_q == STARVE_LIM));

    always_comb begin
        state_d   = state_q;
        gnt_d_d   = gnt_d_q;
        wr_d      = wr_q;
        starve_d  = starve_q;
        memw_d    = 1'b0;
        memr_d    = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        p_rdata_d = p_rdata_q;
        d_rdata_d = d_rdata_q;
        p_ack_d   = 1'b0;
        d_ack_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.P_Req | bus.D_Req) begin
                    gnt_d_d = d_win;
                    wr_d    = d_win ? bus.D_Wr    : bus.P_Wr;
                    addr_d  = d_win ? bus.D_Addr  : bus.P_Addr;
                    wdata_d = d_win ? bus.D_WData : bus.P_WData;
                    memw_d  = wr_d;
                    memr_d  = ~wr_d;
                    state_d = S_ISSUE;
                    if (d_win || !bus.D_Req)
                        starve_d = 4'd0;
                    else if (starve_q != STARVE_LIM)
                        starve_d = starve_q + 4'd1;
                end
            end
            S_ISSUE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                // Memory registered its read on the ISSUE edge, so MemoryOut is valid here.
                if (!wr_q) begin
                    if (gnt_d_q) d_rdata_d = bus.MemoryOut;
                    else         p_rdata_d = bus.MemoryOut;
                end
                d_ack_d = gnt_d_q;
                p_ack_d = ~gnt_d_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            gnt_d_q   <= 1'b0;
            wr_q      <= 1'b0;
            starve_q  <= 4'd0;
            memw_q    <= 1'b0;
            memr_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            p_rdata_q <= '0;
            d_rdata_q <= '0;
            p_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_d_q   <= gnt_d_d;
            wr_q      <= wr_d;
            starve_q  <= starve_d;
            memw_q    <= memw_d;
            memr_q    <= memr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            p_rdata_q <= p_rdata_d;
            d_rdata_q <= d_rdata_d;
            p_ack_q   <= p_ack_d;
            d_ack_q   <= d_ack_d;
        end
    end

    assign bus.MemW    = memw_q;
    assign bus.MemR    = memr_q;
    assign bus.Address = addr_q;
    assign bus.DataIn  = wdata_q;
    assign bus.P_RData = p_rdata_q;
    assign bus.D_RData = d_rdata_q;
    assign bus.P_Ack   = p_ack_q;
    assign bus.D_Ack   = d_ack_q;
    assign bus.Stall   = bus.P_Req & ~p_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered-read memory model (mem[a] starts as a).
module tb_dmem_arbiter;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    logic [15:0] mem [0:255];

    dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.MemW) mem[bus.Address[7:0]] <= bus.DataIn;
        if (bus.MemR) bus.MemoryOut <= mem[bus.Address[7:0]];
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic p_drive(input logic req, input logic wr, input logic [15:0] a, input logic [15:0] d);
        bus.P_Req = req; bus.P_Wr = wr; bus.P_Addr = a; bus.P_WData = d;
    endtask

    task automatic d_drive(input logic req, input logic wr, input logic [15:0] a, input logic [15:0] d);
        bus.D_Req = req; bus.D_Wr = wr; bus.D_Addr = a; bus.D_WData = d;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) mem[i] <= 16'(i);

        // Reset with P_Req held
        reset_n = 1'b0;
        p_drive(1'b1, 1'b0, 16'd0, 16'd0);
        d_drive(1'b0, 1'b0, 16'd0, 16'd0);
        tick();
        tick();
        chk("rst_memw",    32'(bus.MemW),    32'd0);
        chk("rst_memr",    32'(bus.MemR),    32'd0);
        chk("rst_addr",    32'(bus.Address), 32'd0);
        chk("rst_datain",  32'(bus.DataIn),  32'd0);
        chk("rst_p_rdata", 32'(bus.P_RData), 32'd0);
        chk("rst_d_rdata", 32'(bus.D_RData), 32'd0);
        chk("rst_p_ack",   32'(bus.P_Ack),   32'd0);
        chk("rst_d_ack",   32'(bus.D_Ack),   32'd0);
        chk("rst_stall",   32'(bus.Stall),   32'd1);
        p_drive(1'b0, 1'b0, 16'd0, 16'd0);
        reset_n = 1'b1;
        tick();

        // P write 3333 -> addr 2
        p_drive(1'b1, 1'b1, 16'd2, 16'h3333);
        tick();
        chk("pw_memw",   32'(bus.MemW),    32'd1);
        chk("pw_memr",   32'(bus.MemR),    32'd0);
        chk("pw_addr",   32'(bus.Address), 32'd2);
        chk("pw_datain", 32'(bus.DataIn),  32'h3333);
        chk("pw_stall",  32'(bus.Stall),   32'd1);
        tick();
        chk("pw_memw_1cyc", 32'(bus.MemW),  32'd0);
        chk("pw_ack_early", 32'(bus.P_Ack), 32'd0);
        tick();
        chk("pw_ack",        32'(bus.P_Ack), 32'd1);
        chk("pw_stall_ack",  32'(bus.Stall), 32'd0);
        chk("pw_rdata_keep", 32'(bus.P_RData), 32'd0);
        p_drive(1'b0, 1'b0, 16'd0, 16'd0);
        tick();
        chk("pw_ack_pulse", 32'(bus.P_Ack), 32'd0);
        chk("pw_idle_memw", 32'(bus.MemW),  32'd0);
        chk("pw_addr_hold", 32'(bus.Address), 32'd2);

        // P read addr 2
        p_drive(1'b1, 1'b0, 16'd2, 16'd0);
        tick();
        chk("pr_memr", 32'(bus.MemR), 32'd1);
        chk("pr_memw", 32'(bus.MemW), 32'd0);
        tick();
        tick();
        chk("pr_ack",   32'(bus.P_Ack),   32'd1);
        chk("pr_rdata", 32'(bus.P_RData), 32'h3333);
        p_drive(1'b0, 1'b0, 16'd0, 16'd0);
        tick();
        chk("pr_rdata_hold", 32'(bus.P_RData), 32'h3333);

        // Simultaneous P read 5 / D read 7
        p_drive(1'b1, 1'b0, 16'd5, 16'd0);
        d_drive(1'b1, 1'b0, 16'd7, 16'd0);
        tick();
        chk("sim_p_first", 32'(bus.Address), 32'd5);
        tick();
        tick();
        chk("sim_p_ack",   32'(bus.P_Ack),   32'd1);
        chk("sim_p_rdata", 32'(bus.P_RData), 32'd5);
        chk("sim_d_wait",  32'(bus.D_Ack),   32'd0);
        p_drive(1'b0, 1'b0, 16'd0, 16'd0);
        tick();
        chk("sim_d_addr", 32'(bus.Address), 32'd7);
        chk("sim_d_memr", 32'(bus.MemR),    32'd1);
        tick();
        tick();
        chk("sim_d_ack",   32'(bus.D_Ack),   32'd1);
        chk("sim_d_rdata", 32'(bus.D_RData), 32'd7);
        chk("sim_p_keep",  32'(bus.P_RData), 32'd5);
        d_drive(1'b0, 1'b0, 16'd0, 16'd0);
        tick();

        // Starvation guard: P reads addr 1 continuously, D wants addr 9
        p_drive(1'b1, 1'b0, 16'd1, 16'd0);
        d_drive(1'b1, 1'b0, 16'd9, 16'd0);
        for (int g = 0; g < 4; g++) begin
            tick();
            chk($sformatf("stv_p_grant%0d", g), 32'(bus.Address), 32'd1);
            tick();
            tick();
            chk($sformatf("stv_p_ack%0d", g), 32'(bus.P_Ack), 32'd1);
        end
        tick();
        chk("stv_d_grant", 32'(bus.Address), 32'd9);
        tick();
        tick();
        chk("stv_d_ack",   32'(bus.D_Ack),   32'd1);
        chk("stv_d_rdata", 32'(bus.D_RData), 32'd9);
        chk("stv_p_noack", 32'(bus.P_Ack),   32'd0);
        // D still requesting: a cleared counter lets P win again
        tick();
        chk("stv_cnt_clr", 32'(bus.Address), 32'd1);
        tick();
        tick();
        chk("stv_p_ack5", 32'(bus.P_Ack), 32'd1);
        p_drive(1'b0, 1'b0, 16'd0, 16'd0);
        d_drive(1'b0, 1'b0, 16'd0, 16'd0);
        tick();

        // Reset during DONE of a D read
        d_drive(1'b1, 1'b0, 16'd7, 16'd0);
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        chk("rmid_no_ack", 32'(bus.D_Ack),   32'd0);
        chk("rmid_rdata",  32'(bus.D_RData), 32'd0);
        reset_n = 1'b1;
        d_drive(1'b0, 1'b0, 16'd0, 16'd0);
        tick();

        // Write abcd -> addr 4, reset during DONE, then read back
        d_drive(1'b1, 1'b1, 16'd4, 16'habcd);
        tick();
        chk("rw_memw", 32'(bus.MemW), 32'd1);
        tick();
        reset_n = 1'b0;
        tick();
        chk("rw_no_ack", 32'(bus.D_Ack), 32'd0);
        reset_n = 1'b1;
        d_drive(1'b0, 1'b0, 16'd0, 16'd0);
        tick();
        d_drive(1'b1, 1'b0, 16'd4, 16'd0);
        tick();
        chk("rw_rd_addr", 32'(bus.Address), 32'd4);
        tick();
        tick();
        chk("rw_rd_ack",   32'(bus.D_Ack),   32'd1);
        chk("rw_rd_rdata", 32'(bus.D_RData), 32'habcd);
        d_drive(1'b0, 1'b0, 16'd0, 16'd0);
        tick();

        // Stall: P raised while D read of addr 3 is in ISSUE
        d_drive(1'b1, 1'b0, 16'd3, 16'd0);
        tick();
        p_drive(1'b1, 1'b0, 16'd6, 16'd0);
        #1;
        chk("stall_c0", 32'(bus.Stall), 32'd1);
        tick();
        chk("stall_c1", 32'(bus.Stall), 32'd1);
        tick();
        chk("stall_c2",    32'(bus.Stall),   32'd1);
        chk("stall_d_ack", 32'(bus.D_Ack),   32'd1);
        chk("stall_d_rd",  32'(bus.D_RData), 32'd3);
        d_drive(1'b0, 1'b0, 16'd0, 16'd0);
        tick();
        chk("stall_c3",     32'(bus.Stall),   32'd1);
        chk("stall_p_addr", 32'(bus.Address), 32'd6);
        tick();
        chk("stall_c4", 32'(bus.Stall), 32'd1);
        tick();
        chk("stall_c5_off", 32'(bus.Stall),   32'd0);
        chk("stall_p_ack",  32'(bus.P_Ack),   32'd1);
        chk("stall_p_rd",   32'(bus.P_RData), 32'd6);
        p_drive(1'b0, 1'b0, 16'd0, 16'd0);
        tick();

        // A P write must leave P_RData untouched
        p_drive(1'b1, 1'b1, 16'd10, 16'h1234);
        tick();
        tick();
        tick();
        chk("wkeep_ack",   32'(bus.P_Ack),   32'd1);
        chk("wkeep_rdata", 32'(bus.P_RData), 32'd6);
        p_drive(1'b0, 1'b0, 16'd0, 16'd0);
        tick();
        chk("wkeep_mem", 32'(mem[10]), 32'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the 16-bit data memory. It shares the single memory port between the pipeline MEM stage (port P) and the program/data loader (port D). It serialises their read/write requests into single-cycle memory commands, returns read data, and raises a pipeline stall while a P access is outstanding. It sits between the MEM stage / loader and the data memory.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- STARVE_MAX, 4, consecutive P grants allowed while D waits (1..15)

- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- P_Req  in  1  pipeline request; held until P_Ack
- P_Wr  in  1  1 = write, 0 = read
- P_Addr  in  ADDR_W  pipeline address
- P_WData  in  DATA_W  pipeline write data
- P_RData  out  DATA_W  pipeline read data, valid while P_Ack=1
- P_Ack  out  1  one-cycle completion pulse
- Stall  out  1  P_Req & ~P_Ack (combinational)
- D_Req, D_Wr, D_Addr, D_WData, D_RData, D_Ack  same widths and roles for the loader port
- MemW  out  1  memory write enable
- MemR  out  1  memory read enable
- Address  out  ADDR_W  memory address
- DataIn  out  DATA_W  memory write data
- MemoryOut  in  DATA_W  memory read data; registered in memory, valid after the edge that samples MemR

## Operation
- FSM states: IDLE, ISSUE, DONE. All outputs except Stall are registered.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise select a winner, latch its Wr/Addr/WData and a grant bit, and go to ISSUE.
- Selection rule:
  - P wins by default.
  - D wins if only D_Req is high, or if both are high and starve_cnt == STARVE_MAX.
- ISSUE (exactly one cycle):
  - Address and DataIn show the latched values.
  - MemW = latched Wr; MemR = ~latched Wr.
  - Next state is DONE.
- DONE (one cycle):
  - MemW = MemR = 0.
  - On read, copy MemoryOut into the winner's RData register.
  - Pulse the winner's Ack (registered, high for the following cycle).
  - Next state is IDLE.
- MemW and MemR are never high together. Both are 0 outside ISSUE.
- A write leaves RData unchanged.
- Each RData register holds its value until that port's next read completes.
- starve_cnt (4 bits):
  - +1 on each P grant while D_Req = 1.
  - Cleared on each D grant, and on any P grant with D_Req = 0.
  - Saturates at STARVE_MAX.
- Requester rules:
  - Req, Wr, Addr and WData must stay stable from assertion until Ack.
  - Req must drop in the cycle where Ack = 1. If Req is still high in that cycle, the IDLE sampling edge starts a new access.
- Address and DataIn keep their last values in IDLE and DONE.

## Timing
- Edge 0: IDLE samples Req; signals move to ISSUE values.
- Edge 1: the memory samples MemW/MemR; MemoryOut becomes valid.
- Edge 2: DONE captures MemoryOut; Ack and RData are high/valid in cycle 2→3.
- Edge 3: IDLE samples again.
- Throughput is one access per 3 cycles. P read-to-data latency is 3 cycles from Req assertion.
- Reset, when reset_n = 0 at an edge:
  - state = IDLE, starve_cnt = 0, grant cleared.
  - MemW = MemR = 0, Address = DataIn = 0.
  - P_RData = D_RData = 0, P_Ack = D_Ack = 0.
  - Stall follows P_Req.
- Reset mid-operation:
  - The access is abandoned and no Ack is issued.
  - A write whose ISSUE edge has already passed stays committed in memory.
- A request arriving while the FSM is in ISSUE or DONE waits and is considered at the next IDLE edge.

## Test plan
- Reset check: hold reset_n = 0 for 2 cycles with P_Req = 1 → all registered outputs 0, Stall = 1, no MemR/MemW.
- P write then read:
  - Write 16'h3333 to address 2 → MemW high for exactly one cycle with Address = 2, DataIn = 3333; P_Ack pulses at cycle +3.
  - Read address 2 → P_RData = 16'h3333 while P_Ack = 1.
- Simultaneous requests: P reads address 5, D reads address 7, both raised on the same edge → P is served first (P_RData = 5); D follows 3 cycles later (D_RData = 7).
- Starvation guard: P_Req held continuously issuing reads, D_Req high throughout → after 4 P grants, the 5th grant goes to D; starve_cnt returns to 0.
- Reset mid-access: assert reset_n = 0 during DONE of a D read → no D_Ack; D_RData = 0. A write reset during DONE is still visible on a later read.
- Stall: P_Req raised while a D access is in ISSUE → Stall = 1 for 5 cycles, deasserting in the cycle P_Ack = 1.
